sdram_ctrlmod: RTL and testbench

Control stage directly upstream of the SDRAM function module. It sequences power-up initialisation, inserts periodic auto-refresh, and arbitrates user write/read requests. It translates them into one-hot calls to the function module (bit3 write, bit2 read, bit1 refresh, bit0 init) and returns a one-cycle done pulse to the user. Address and data buses are wired from the user straight to the function module at top level and do not pass through this block.

---
 rtl/sdram_ctrlmod.sv | 135 +++++++++++++
 tb/tb_sdram_ctrlmod.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrlmod.sv
// Sequencer in front of the SDRAM function module: power-up init, periodic auto-refresh
// and write/read arbitration. Auto-refresh is built only when SDRAM_AUTO_REFRESH_EN is defined.
module sdram_ctrlmod (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] iCall,
  input  logic       iDone,
  output logic       oDone,
  output logic       oReady,
  output logic [3:0] oCall
);

  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, REFRESH, DONE} state_e;

  localparam logic [3:0] CALL_NONE = 4'b0000;
  localparam logic [3:0] CALL_INIT = 4'b0001;
  localparam logic [3:0] CALL_REF  = 4'b0010;
  localparam logic [3:0] CALL_RD   = 4'b0100;
  localparam logic [3:0] CALL_WR   = 4'b1000;

  state_e     state_q, state_d;
  logic [3:0] call_q, call_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam logic [13:0] TREF = 14'd1040;

  logic [13:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d;
  logic        ref_take;

  // Counter free-runs once ready; a wrap on the same edge as a take keeps the new request.
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (ref_take) ref_pend_d = 1'b0;
    if (ready_q) begin
      if (ref_cnt_q == TREF - 14'd1) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 14'd1;
      end
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    call_d  = call_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef SDRAM_AUTO_REFRESH_EN
    ref_take = 1'b0;
`endif
    unique case (state_q)
      INIT: begin
        if (call_q[0] && iDone) begin
          call_d  = CALL_NONE;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          call_d = CALL_INIT;
        end
      end
      IDLE: begin
        call_d = CALL_NONE;
`ifdef SDRAM_AUTO_REFRESH_EN
        if (ref_pend_q) begin
          call_d   = CALL_REF;
          state_d  = REFRESH;
          ref_take = 1'b1;
        end else
`endif
        if (iCall[1]) begin
          call_d  = CALL_WR;
          state_d = WRITE;
        end else if (iCall[0]) begin
          call_d  = CALL_RD;
          state_d = READ;
        end
      end
      WRITE, READ: begin
        if (iDone) begin
          call_d  = CALL_NONE;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`ifdef SDRAM_AUTO_REFRESH_EN
      REFRESH: begin
        if (iDone) begin
          call_d  = CALL_NONE;
          state_d = IDLE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: begin
        call_d  = CALL_NONE;
        state_d = INIT;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= INIT;
      call_q     <= CALL_NONE;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
`ifdef SDRAM_AUTO_REFRESH_EN
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      call_q     <= call_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
`ifdef SDRAM_AUTO_REFRESH_EN
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
`endif
    end
  end

  assign oCall  = call_q;
  assign oDone  = done_q;
  assign oReady = ready_q;

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Bench for sdram_ctrlmod: function-module model plus scenario tasks checked against
// timing expectations derived from the controller's documented rules.
module tb_sdram_ctrlmod;

  localparam int TREF = 1040;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] iCall = 2'b00;
  logic       iDone = 1'b0;
  logic       oDone, oReady;
  logic [3:0] oCall;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fm_lat = 20;
  int fm_cnt = 0;

  int n_done = 0, n_wr = 0, n_rd = 0, n_ref = 0, n_multi = 0, n_ref_bit = 0;
  int last_ref_end = -100000;
  int ref_q[$];
  logic [3:0] prev_call = 4'b0000;
  int ready_cyc = 0;

  sdram_ctrlmod dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iCall (iCall),
    .iDone (iDone),
    .oDone (oDone),
    .oReady(oReady),
    .oCall (oCall)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc++;

  // Function-module model (returns iDone fm_lat cycles into a call) and event monitor.
  always @(negedge CLOCK) begin
    if (oCall !== 4'b0000) begin
      fm_cnt++;
      iDone = (fm_cnt >= fm_lat);
    end else begin
      fm_cnt = 0;
      iDone  = 1'b0;
    end
    if ($countones(oCall) > 1) n_multi++;
    if (oCall[1] === 1'b1) n_ref_bit++;
    if (oCall !== prev_call) begin
      if (oCall === 4'b1000) n_wr++;
      if (oCall === 4'b0100) n_rd++;
      if (oCall === 4'b0010) begin
        n_ref++;
        ref_q.push_back(cyc);
      end
    end
    if (prev_call[1] === 1'b1 && oCall[1] !== 1'b1) last_ref_end = cyc;
    if (oDone === 1'b1) n_done++;
    prev_call = oCall;
  end

  task automatic step();
    @(negedge CLOCK);
    #1;
  endtask

  // Issues one user request and measures when the call appears, how long it lasts,
  // and whether oDone follows; iCall is set to after_req on the oDone cycle.
  task automatic do_access(input logic [1:0] req, input logic [3:0] exp_call,
                           input logic [1:0] after_req, output int req_cyc,
                           output int start_cyc, output int dur, output logic done_ok,
                           output int ref_during);
    int n;
    int ref0;
    iCall   = req;
    req_cyc = cyc;
    n       = 0;
    do begin
      step();
      n++;
    end while (oCall !== exp_call && n < 200);
    start_cyc = cyc;
    ref0      = n_ref;
    dur       = 0;
    while (oCall === exp_call && dur < 200) begin
      dur++;
      step();
    end
    done_ok    = (oDone === 1'b1) && (oCall === 4'b0000);
    ref_during = n_ref - ref0;
    iCall      = after_req;
  endtask

  task automatic test_reset();
    fm_lat = 20;
    repeat (3) step();
    checks++;
    if ({oReady, oDone, oCall} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 000000", {oReady, oDone, oCall});
    end
    RESET = 1'b1;
    iCall = 2'b01;
    step();
    checks++;
    if (oCall !== 4'b0001) begin
      errors++;
      $display("FAIL init_first_edge: oCall=%b, want 0001", oCall);
    end
    for (int i = 1; i < 20; i++) begin
      step();
      checks++;
      if ({oReady, oCall} !== 5'b00001) begin
        errors++;
        $display("FAIL init_hold cycle %0d: {oReady,oCall}=%b, want 00001", i, {oReady, oCall});
      end
    end
    iCall = 2'b00;
    step();
    checks++;
    if ({oReady, oDone, oCall} !== 6'b100000) begin
      errors++;
      $display("FAIL init_done: {oReady,oDone,oCall}=%b, want 100000", {oReady, oDone, oCall});
    end
    ready_cyc = cyc;
    step();
    checks++;
    if (oCall !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_call: oCall=%b, want 0000", oCall);
    end
  endtask

  task automatic test_write();
    int rq, st, du, rd, wr0, dn0;
    logic ok;
    wr0 = n_wr;
    dn0 = n_done;
    fm_lat = 8;
    do_access(2'b10, 4'b1000, 2'b00, rq, st, du, ok, rd);
    checks++;
    if (st != rq + 1) begin
      errors++;
      $display("FAIL write_latency: call at %0d, want %0d", st, rq + 1);
    end
    checks++;
    if (du != 8) begin
      errors++;
      $display("FAIL write_duration: %0d cycles, want 8", du);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_done: oDone=%b oCall=%b, want 1 0000", oDone, oCall);
    end
    repeat (6) step();
    checks++;
    if (n_done - dn0 != 1) begin
      errors++;
      $display("FAIL write_done_count: %0d pulses, want 1", n_done - dn0);
    end
    checks++;
    if (n_wr - wr0 != 1 || oCall !== 4'b0000) begin
      errors++;
      $display("FAIL write_no_second_call: %0d calls oCall=%b, want 1 0000", n_wr - wr0, oCall);
    end
  endtask

  task automatic test_both();
    int rq, st, du, rd, lat, wr0, rd0, dn0, done_c;
    logic ok;
    wr0 = n_wr;
    rd0 = n_rd;
    dn0 = n_done;
    lat = 3 + int'($urandom_range(0, 3));
    fm_lat = lat;
    do_access(2'b11, 4'b1000, 2'b01, rq, st, du, ok, rd);
    done_c = cyc;
    checks++;
    if (st != rq + 1 || du != lat || !ok) begin
      errors++;
      $display("FAIL both_write_first: start %0d dur %0d done %b, want %0d %0d 1",
               st, du, ok, rq + 1, lat);
    end
    do_access(2'b01, 4'b0100, 2'b00, rq, st, du, ok, rd);
    checks++;
    if (st != done_c + 2) begin
      errors++;
      $display("FAIL both_read_after: read at %0d, want %0d", st, done_c + 2);
    end
    checks++;
    if (du != lat || !ok) begin
      errors++;
      $display("FAIL both_read_done: dur %0d done %b, want %0d 1", du, ok, lat);
    end
    repeat (4) step();
    checks++;
    if (n_done - dn0 != 2 || n_wr - wr0 != 1 || n_rd - rd0 != 1) begin
      errors++;
      $display("FAIL both_counts: done %0d wr %0d rd %0d, want 2 1 1",
               n_done - dn0, n_wr - wr0, n_rd - rd0);
    end
  endtask

  task automatic test_refresh_idle();
    int ref0, dn0;
    ref0   = ref_q.size();
    dn0    = n_done;
    fm_lat = 4;
    while (cyc < ready_cyc + 3 * TREF + 5) step();
`ifdef SDRAM_AUTO_REFRESH_EN
    checks++;
    if (ref_q.size() - ref0 != 3) begin
      errors++;
      $display("FAIL refresh_count: %0d refreshes, want 3", ref_q.size() - ref0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ref_q[ref0 + k] != ready_cyc + (k + 1) * TREF + 1) begin
          errors++;
          $display("FAIL refresh_time %0d: at %0d, want %0d", k, ref_q[ref0 + k],
                   ready_cyc + (k + 1) * TREF + 1);
        end
      end
    end
`else
    checks++;
    if (n_ref_bit != 0) begin
      errors++;
      $display("FAIL refresh_absent: oCall[1] high for %0d cycles, want 0", n_ref_bit);
    end
`endif
    checks++;
    if (n_done != dn0) begin
      errors++;
      $display("FAIL refresh_no_done: %0d pulses, want 0", n_done - dn0);
    end
  endtask

`ifdef SDRAM_AUTO_REFRESH_EN
  task automatic test_refresh_during_read();
    int rq, st, du, rd, ref0, done_c;
    logic ok;
    while (cyc < ready_cyc + 4 * TREF - 5) step();
    ref0   = n_ref;
    fm_lat = 20;
    do_access(2'b01, 4'b0100, 2'b10, rq, st, du, ok, rd);
    done_c = cyc;
    checks++;
    if (st != rq + 1 || du != 20 || !ok || rd != 0) begin
      errors++;
      $display("FAIL refresh_read_intact: start %0d dur %0d done %b ref %0d, want %0d 20 1 0",
               st, du, ok, rd, rq + 1);
    end
    fm_lat = 6;
    do_access(2'b10, 4'b1000, 2'b00, rq, st, du, ok, rd);
    checks++;
    if (n_ref - ref0 != 1 || ref_q[$] != done_c + 2) begin
      errors++;
      $display("FAIL refresh_after_read: %0d refreshes, last at %0d, want 1 at %0d",
               n_ref - ref0, ref_q[$], done_c + 2);
    end
    checks++;
    if (st != done_c + 9 || du != 6 || !ok) begin
      errors++;
      $display("FAIL refresh_write_queued: start %0d dur %0d done %b, want %0d 6 1",
               st, du, ok, done_c + 9);
    end
  endtask
`endif

  task automatic test_random();
    int start_c, end_c, r0, exp_wraps, w;
    start_c = cyc;
    r0      = n_ref;
    for (int i = 0; i < 200 && errors < 50; i++) begin
      int rq, st, du, rd, lat, gap, exp_st;
      logic ok, is_wr;
      logic [1:0] req;
      logic [3:0] exp_call;
      is_wr = 1'($urandom_range(0, 1));
      lat   = int'($urandom_range(1, 12));
      gap   = int'($urandom_range(1, 3));
      repeat (gap) step();
      fm_lat = lat;
      if (is_wr) begin
        req      = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
        exp_call = 4'b1000;
      end else begin
        req      = 2'b01;
        exp_call = 4'b0100;
      end
      do_access(req, exp_call, 2'b00, rq, st, du, ok, rd);
      exp_st = (last_ref_end + 1 > rq + 1) ? last_ref_end + 1 : rq + 1;
      checks++;
      if (st != exp_st) begin
        errors++;
        $display("FAIL rand_start %0d: req %b call at %0d, want %0d", i, req, st, exp_st);
      end
      checks++;
      if (du != lat || !ok) begin
        errors++;
        $display("FAIL rand_complete %0d: dur %0d done %b, want %0d 1", i, du, ok, lat);
      end
      checks++;
      if (rd != 0) begin
        errors++;
        $display("FAIL rand_no_preempt %0d: %0d refreshes inside access, want 0", i, rd);
      end
    end
    repeat (40) step();
    end_c     = cyc;
    exp_wraps = 0;
`ifdef SDRAM_AUTO_REFRESH_EN
    for (int k = 1; k < 20; k++) begin
      w = ready_cyc + k * TREF;
      if (w >= start_c && w <= end_c - 1) exp_wraps++;
    end
`endif
    checks++;
    if (n_ref - r0 != exp_wraps) begin
      errors++;
      $display("FAIL rand_refresh_count: %0d, want %0d", n_ref - r0, exp_wraps);
    end
    checks++;
    if (oReady !== 1'b1) begin
      errors++;
      $display("FAIL rand_ready_held: oReady=%b, want 1", oReady);
    end
  endtask

  task automatic test_reset_mid_write();
    int rq, st, du, rd, dn0, n;
    logic ok;
    dn0    = n_done;
    fm_lat = 30;
    iCall  = 2'b10;
    repeat (3) step();
    checks++;
    if (oCall !== 4'b1000) begin
      errors++;
      $display("FAIL rst_pre_write: oCall=%b, want 1000", oCall);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({oReady, oDone, oCall} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_async: {oReady,oDone,oCall}=%b, want 000000", {oReady, oDone, oCall});
    end
    iCall  = 2'b00;
    fm_lat = 20;
    repeat (2) step();
    RESET = 1'b1;
    step();
    checks++;
    if ({oReady, oCall} !== 5'b00001) begin
      errors++;
      $display("FAIL rst_reinit: {oReady,oCall}=%b, want 00001", {oReady, oCall});
    end
    n = 0;
    while (oReady !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (oReady !== 1'b1 || n != 20) begin
      errors++;
      $display("FAIL rst_ready: oReady=%b after %0d cycles, want 1 after 20", oReady, n);
    end
    checks++;
    if (n_done != dn0) begin
      errors++;
      $display("FAIL rst_no_done: %0d pulses, want 0", n_done - dn0);
    end
    step();
    fm_lat = 5;
    do_access(2'b10, 4'b1000, 2'b00, rq, st, du, ok, rd);
    checks++;
    if (st != rq + 1 || du != 5 || !ok) begin
      errors++;
      $display("FAIL rst_write_after: start %0d dur %0d done %b, want %0d 5 1", st, du, ok, rq + 1);
    end
  endtask

  initial begin
    #1 RESET = 1'b0;
    test_reset();
    test_write();
    test_both();
    test_refresh_idle();
`ifdef SDRAM_AUTO_REFRESH_EN
    test_refresh_during_read();
`endif
    test_random();
    test_reset_mid_write();
    repeat (4) step();
    checks++;
    if (n_multi != 0) begin
      errors++;
      $display("FAIL onehot: %0d cycles with several oCall bits, want 0", n_multi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
